// File: rtl/legv8_fetch_unit_if.sv
// Instruction-memory fetch handshake between the LEGv8 fetch unit and its memory.
interface legv8_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch unit: owns PC and IR, fetches over a req/ready handshake and
// computes the next PC from the control unit's select code.
module legv8_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  legv8_fetch_unit_if.master     imem,
  input  logic                   i_pc_update,
  input  logic [1:0]             i_pc_sel,
  input  logic [63:0]            i_constant,
  input  logic [63:0]            i_reg_target,
  output logic [31:0]            o_instruction,
  output logic                   o_instr_valid,
  output logic [63:0]            o_pc,
  output logic [63:0]            o_pc_plus4,
  output logic                   o_misaligned,
  output logic [COUNT_WIDTH-1:0] o_retired
);

  typedef enum logic {S_FETCH = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [63:0]            r_pc;
  logic [31:0]            r_ir;
  logic                   r_misaligned;
  logic [COUNT_WIDTH-1:0] r_retired;

  logic                   w_req;
  logic                   w_valid;
  logic                   w_load_ir;
  logic                   w_take;
  logic [63:0]            w_pc_plus4;
  logic [63:0]            w_next_pc;
  logic                   w_br_misaligned;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    w_load_ir   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem.imem_ready) begin
          w_load_ir   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_valid = 1'b1;
        if (i_pc_update) begin
          w_take      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign w_pc_plus4 = r_pc + 64'd4;

  always_comb begin
    w_next_pc = r_pc;
    case (i_pc_sel)
      2'b00:   w_next_pc = r_pc;
      2'b01:   w_next_pc = w_pc_plus4;
      2'b10:   w_next_pc = r_pc + (i_constant << 2);
      default: w_next_pc = {i_reg_target[63:2], 2'b00};
    endcase
  end

  assign w_br_misaligned = w_take && (i_pc_sel == 2'b11) && (i_reg_target[1:0] != 2'b00);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc         <= RESET_PC;
      r_ir         <= 32'h0;
      r_misaligned <= 1'b0;
      r_retired    <= '0;
    end else begin
      if (w_load_ir) r_ir <= imem.imem_rdata;
      if (w_take) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 1'b1;
      end
      if (w_br_misaligned) r_misaligned <= 1'b1;
    end
  end

  // Reset forces the state to FETCH, so the request must be gated by reset itself.
  assign imem.imem_req  = w_req & ~i_reset;
  assign imem.imem_addr = r_pc;
  assign o_instruction  = r_ir;
  assign o_instr_valid  = w_valid;
  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_misaligned   = r_misaligned;
  assign o_retired      = r_retired;

endmodule
